// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a single-port memory shared by instruction fetch and
// the MEM stage; counts fixed read latency, returns data with a ready pulse.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_D,
    DONE_IF,
    DONE_D
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              kill_pend_q, kill_pend_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              lat_done;

  assign lat_done = (lat_cnt_q == LW'(MEM_LAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      kill_pend_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      kill_pend_q <= kill_pend_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    kill_pend_d = kill_pend_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        // A data grant with fetch pending implies starve_q < MAX_STARVE,
        // so the increment below saturates by construction.
        if (d_req && ((starve_q < SW'(MAX_STARVE)) || !if_req)) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          if (if_req) starve_d = starve_q + SW'(1);
          if (d_we) begin
            state_d = DONE_D;
          end else begin
            state_d   = BUSY_D;
            lat_cnt_d = LW'(1);
          end
        end else if (if_req) begin
          mem_en    = 1'b1;
          mem_addr  = if_addr;
          starve_d  = '0;
          state_d   = BUSY_IF;
          lat_cnt_d = LW'(1);
        end
      end
      BUSY_IF: begin
        if (if_kill) kill_pend_d = 1'b1;
        if (lat_done) begin
          if (!kill_pend_q && !if_kill) if_rdata_d = mem_rdata;
          state_d = DONE_IF;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      BUSY_D: begin
        if (lat_done) begin
          d_rdata_d = mem_rdata;
          state_d   = DONE_D;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      DONE_IF, DONE_D: begin
        state_d     = IDLE;
        kill_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_ready  = (state_q == DONE_IF) && !kill_pend_q && !if_kill;
  assign d_ready   = (state_q == DONE_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level timing/arbitration
// model predicts every cycle's memory bus, ready pulses, stalls and data.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int MS  = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_kill = 1'b0, if_ready;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0, d_ready;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0, d_rdata;
  logic          stall_if, stall_mem, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata = '0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_STARVE(MS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int          cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    logic [3:0] w;
    w = 4'($urandom);
    return {26'b0, w, 2'b00};
  endfunction

  typedef struct { int cyc; logic [DW-1:0] data; } rd_t;
  rd_t rdq[$];
  logic [DW-1:0] mem [16];

  // Requester state
  bit            if_act, d_act, d_w;
  logic [AW-1:0] if_a, d_a;
  logic [DW-1:0] d_wd;

  // Reference model: one transaction at a time, timing from issue cycle
  int            m_owner;   // 0 none, 1 fetch, 2 data
  int            m_issue, m_ready, m_starve;
  bit            m_write, m_killed;
  logic [DW-1:0] m_data, e_if_rdata, e_d_rdata;

  initial begin
    bit rst_now, kill_win, free, gd, gi;
    bit e_en, e_we, e_ifr, e_dr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    if_act = 0; d_act = 0; d_w = 0; if_a = '0; d_a = '0; d_wd = '0;
    m_owner = 0; m_issue = 0; m_ready = 0; m_starve = 0;
    m_write = 0; m_killed = 0; m_data = '0; e_if_rdata = '0; e_d_rdata = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      rst_now = (cyc < 2) || (cyc % 613 == 300);
      rst = rst_now;
      if (!if_act && $urandom_range(0, 3) != 0) begin
        if_act = 1; if_a = rnd_addr();
      end
      if (!d_act && $urandom_range(0, 2) != 0) begin
        d_act = 1; d_w = ($urandom_range(0, 2) == 0); d_a = rnd_addr(); d_wd = $urandom;
      end
      if_kill = 1'b0;
      kill_win = (m_owner == 1) && (cyc > m_issue) && (cyc <= m_ready);
      if (!rst_now && kill_win && cyc <= m_issue + LAT && !m_killed &&
          $urandom_range(0, 5) == 0) begin
        if_kill = 1'b1; m_killed = 1; if_a = rnd_addr();
      end else if (!kill_win && $urandom_range(0, 7) == 0) begin
        if_kill = 1'b1;  // should be ignored outside an outstanding fetch
      end
      if_req  = if_act;
      if_addr = if_act ? if_a : rnd_addr();
      d_req   = d_act;
      d_we    = d_act ? d_w : 1'($urandom);
      d_addr  = d_act ? d_a : rnd_addr();
      d_wdata = d_act ? d_wd : DW'($urandom);
      while (rdq.size() > 0 && rdq[0].cyc < cyc) void'(rdq.pop_front());
      if (rdq.size() > 0 && rdq[0].cyc == cyc) mem_rdata = rdq.pop_front().data;
      else mem_rdata = $urandom;

      #2;
      if (rst_now) begin
        m_owner = 0; m_starve = 0; m_killed = 0;
        e_if_rdata = '0; e_d_rdata = '0;
        rdq.delete();
        continue;
      end

      e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_ifr = 0; e_dr = 0;
      if (m_owner != 0 && cyc == m_ready) begin
        if (m_owner == 2) begin
          e_dr = 1;
          if (!m_write) e_d_rdata = m_data;
        end else if (!m_killed) begin
          e_ifr = 1;
          e_if_rdata = m_data;
        end
      end
      free = (m_owner == 0) || (cyc > m_ready);
      if (free) begin
        m_owner = 0; m_killed = 0;
        gd = d_req && (m_starve < MS || !if_req);
        gi = !gd && if_req;
        if (!if_req) m_starve = 0;
        else if (gd) m_starve++;
        else if (gi) m_starve = 0;
        if (gd) begin
          e_en = 1; e_we = d_w; e_addr = d_a; e_wd = d_wd;
          m_owner = 2; m_write = d_w; m_issue = cyc;
          m_ready = cyc + (d_w ? 1 : LAT + 1);
          m_data = mem[d_a[5:2]];
        end else if (gi) begin
          e_en = 1; e_addr = if_a;
          m_owner = 1; m_write = 0; m_issue = cyc; m_ready = cyc + LAT + 1;
          m_data = mem[if_a[5:2]];
        end
      end

      check("mem_en",    64'(mem_en),    64'(e_en));
      check("mem_we",    64'(mem_we),    64'(e_we));
      check("mem_addr",  64'(mem_addr),  64'(e_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(e_wd));
      check("if_ready",  64'(if_ready),  64'(e_ifr));
      check("d_ready",   64'(d_ready),   64'(e_dr));
      check("stall_if",  64'(stall_if),  64'(if_req && !e_ifr));
      check("stall_mem", 64'(stall_mem), 64'(d_req && !e_dr));
      check("if_rdata",  64'(if_rdata),  64'(e_if_rdata));
      check("d_rdata",   64'(d_rdata),   64'(e_d_rdata));

      // Memory environment reacts to what the DUT actually drives
      if (mem_en && mem_we) mem[mem_addr[5:2]] = mem_wdata;
      else if (mem_en) rdq.push_back('{cyc: cyc + LAT, data: mem[mem_addr[5:2]]});

      if (e_ifr) if_act = 0;
      if (e_dr) d_act = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
